// File: rtl/multu_seq.sv
// Sequential 32x32 unsigned multiplier that borrows the EX-stage ALU adder.
// Also owns the HI/LO registers behind MFHI, MFLO, MTHI and MTLO.
module multu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] alu_result,
    output logic        alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctl,
    output logic        stall,
    output logic        done,
    output logic        hilo_rd,
    output logic [31:0] hilo_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [2:0] ALU_ADD = 3'b010;

    state_e      state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] mcand_q;
    logic [4:0]  cnt_q;
    logic        done_q;

    logic        dec_en;
    logic        is_multu;
    logic        is_mfhi;
    logic        is_mflo;
    logic        is_mthi;
    logic        is_mtlo;
    logic [31:0] step_sum;
    logic        step_carry;
    logic [63:0] hilo_d;

    // Held instructions are ignored while RUN; they decode once back in IDLE.
    assign dec_en   = valid && (opcode == 6'd0) && (state_q == IDLE);
    assign is_multu = dec_en && (funct == F_MULTU);
    assign is_mfhi  = dec_en && (funct == F_MFHI);
    assign is_mflo  = dec_en && (funct == F_MFLO);
    assign is_mthi  = dec_en && (funct == F_MTHI);
    assign is_mtlo  = dec_en && (funct == F_MTLO);

    // Carry-out of hi + mcand, rebuilt from the operand and sum MSBs.
    assign step_sum   = lo_q[0] ? alu_result : hi_q;
    assign step_carry = lo_q[0]
        & ((hi_q[31] & mcand_q[31])
        | ((hi_q[31] | mcand_q[31]) & ~alu_result[31]));
    assign hilo_d     = {step_carry, step_sum, lo_q[31:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            mcand_q <= 32'd0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (is_multu) begin
                        mcand_q <= a;
                        hi_q    <= 32'd0;
                        lo_q    <= b;
                        cnt_q   <= 5'd0;
                        state_q <= RUN;
                    end else if (is_mthi) begin
                        hi_q <= a;
                    end else if (is_mtlo) begin
                        lo_q <= a;
                    end
                end
                RUN: begin
                    {hi_q, lo_q} <= hilo_d;
                    cnt_q        <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall     = (state_q == RUN);
    assign alu_sel   = (state_q == RUN);
    assign alu_a     = hi_q;
    assign alu_b     = mcand_q;
    assign alu_ctl   = ALU_ADD;
    assign done      = done_q;
    assign hilo_rd   = is_mfhi | is_mflo;
    assign hilo_data = is_mfhi ? hi_q : lo_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_multu_seq.sv
// Scoreboard bench for multu_seq with a behavioural shared ALU.
// Directed vectors push expected products/reads; a monitor pops them.
module tb_multu_seq;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_result;
    logic        alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctl;
    logic        stall;
    logic        done;
    logic        hilo_rd;
    logic [31:0] hilo_data;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        bit          is_prod;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_fail;

    multu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .opcode     (opcode),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .alu_result (alu_result),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctl    (alu_ctl),
        .stall      (stall),
        .done       (done),
        .hilo_rd    (hilo_rd),
        .hilo_data  (hilo_data),
        .hi         (hi),
        .lo         (lo)
    );

    // Shared ALU: adds only when handed over with the add control code.
    assign alu_result = (alu_sel && alu_ctl == 3'b010)
                      ? alu_a + alu_b : 32'hA5A5_5A5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: products on done, then reads on hilo_rd.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done kind", 32'(done), 32'(e.is_prod));
                    chk("product hi", hi, e.hi);
                    chk("product lo", lo, e.lo);
                end
            end
            if (hilo_rd) begin
                if (q.size() == 0) begin
                    chk("unexpected hilo_rd", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("read kind", 32'(!e.is_prod), 32'd1);
                    chk("hilo_data", hilo_data, e.lo);
                end
            end
        end
    end

    task automatic idle_inputs();
        valid  = 1'b0;
        opcode = 6'd0;
        funct  = 6'd0;
        a      = 32'd0;
        b      = 32'd0;
    endtask

    task automatic single_op(input logic [5:0] f, input logic [31:0] x);
        @(posedge clk); #1;
        valid = 1'b1;
        funct = f;
        a     = x;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic read_op(input logic [5:0] f, input logic [31:0] ev);
        q.push_back('{0, 32'd0, ev});
        single_op(f, 32'd0);
    endtask

    // Issue MULTU, optionally hold MFLO in EX through the stall.
    task automatic multu(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input bit hold_mflo);
        int n;
        @(posedge clk); #1;
        valid = 1'b1;
        funct = F_MULTU;
        a     = x;
        b     = y;
        q.push_back('{1, ehi, elo});
        if (hold_mflo) q.push_back('{0, 32'd0, elo});
        @(posedge clk); #1;
        idle_inputs();
        if (hold_mflo) begin
            valid = 1'b1;
            funct = F_MFLO;
        end
        n = 0;
        @(negedge clk);
        while (stall && n < 40) begin
            if (n == 5) begin
                chk("alu_sel in run", 32'(alu_sel), 32'd1);
                if (hold_mflo) chk("hilo_rd in stall", 32'(hilo_rd), 32'd0);
            end
            n++;
            @(negedge clk);
        end
        chk("stall cycles", n, 32'd32);
        if (hold_mflo) begin
            @(posedge clk); #1;
            idle_inputs();
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_inputs();
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst alu_sel", 32'(alu_sel), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst hilo_rd", 32'(hilo_rd), 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst alu_ctl", 32'(alu_ctl), 32'd2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        multu(32'd3, 32'd5, 32'h0, 32'h0000_000F, 0);
        multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0);
        multu(32'h1234_5678, 32'd0, 32'h0, 32'h0, 0);
        multu(32'h8000_0000, 32'd2, 32'h1, 32'h0, 0);
        multu(32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 0);

        single_op(F_MTHI, 32'hDEAD_BEEF);
        single_op(F_MTLO, 32'h0BAD_F00D);
        chk("mthi hi", hi, 32'hDEAD_BEEF);
        chk("mtlo lo", lo, 32'h0BAD_F00D);
        read_op(F_MFHI, 32'hDEAD_BEEF);
        read_op(F_MFLO, 32'h0BAD_F00D);

        multu(32'd7, 32'd9, 32'h0, 32'h0000_003F, 1);

        // Abort mid-run: nothing queued for this one.
        @(posedge clk); #1;
        valid = 1'b1;
        funct = F_MULTU;
        a     = 32'h0000_FFFF;
        b     = 32'h0000_FFFF;
        @(posedge clk); #1;
        idle_inputs();
        repeat (10) @(negedge clk);
        chk("pre-abort stall", 32'(stall), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort stall", 32'(stall), 32'd0);
        chk("abort alu_sel", 32'(alu_sel), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-abort stall", 32'(stall), 32'd0);

        multu(32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 32'hFFFE_0001, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
